// File: rtl/updown_sweep_ctrl.sv
// Sequencer for a free-running 3-bit up/down counter: drives its reset and
// direction so q ping-pongs 0 -> hi, bounces between lo and hi, then returns to 0.
module updown_sweep_ctrl #(
    parameter int W  = 3,
    parameter int PW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          stop,
    input  logic [W-1:0]  lo,
    input  logic [W-1:0]  hi,
    input  logic [PW-1:0] num_peaks,
    input  logic [W-1:0]  q,
    output logic          cnt_rst,
    output logic          updown,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [PW-1:0] peak_cnt
);

    typedef enum logic [1:0] {IDLE, RUN, RET} state_t;

    state_t        state_q;
    logic          dir_q;
    logic [W-1:0]  lo_q, hi_q;
    logic [PW-1:0] np_q, peak_cnt_q;
    logic          done_q, err_q;
    logic [PW-1:0] peak_inc_d;

    assign peak_inc_d = peak_cnt_q + 1'b1;

    // Holding the counter in reset at q==0 during RET keeps it from wrapping to 7.
    assign cnt_rst = rst | (state_q == IDLE) | stop | ((state_q == RET) && (q == '0));

    always_comb begin
        updown = 1'b1;
        case (state_q)
            RUN: begin
                if (q >= hi_q)      updown = 1'b0;
                else if (q <= lo_q) updown = 1'b1;
                else                updown = dir_q;
            end
            RET:     updown = 1'b0;
            default: updown = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            dir_q      <= 1'b1;
            lo_q       <= '0;
            hi_q       <= '0;
            np_q       <= '0;
            peak_cnt_q <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            if (stop) begin
                state_q <= IDLE;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (start) begin
                            if ((lo < hi) && (num_peaks != '0)) begin
                                lo_q       <= lo;
                                hi_q       <= hi;
                                np_q       <= num_peaks;
                                peak_cnt_q <= '0;
                                dir_q      <= 1'b1;
                                state_q    <= RUN;
                            end else begin
                                err_q <= 1'b1;
                            end
                        end
                    end
                    RUN: begin
                        dir_q <= updown;
                        if (q == hi_q) begin
                            peak_cnt_q <= peak_inc_d;
                            if (peak_inc_d == np_q) state_q <= RET;
                        end
                    end
                    RET: begin
                        if (q == '0) begin
                            done_q  <= 1'b1;
                            state_q <= IDLE;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign busy     = (state_q != IDLE);
    assign done     = done_q;
    assign err      = err_q;
    assign peak_cnt = peak_cnt_q;

endmodule

// File: tb/tb_updown_sweep_ctrl.sv
// Directed bench: controller driving a behavioural 3-bit up/down counter.
module tb_updown_sweep_ctrl;

    logic       clk = 1'b0;
    logic       rst, start, stop;
    logic [2:0] lo, hi;
    logic [3:0] num_peaks;
    logic [2:0] q;
    logic       cnt_rst, updown, busy, done, err;
    logic [3:0] peak_cnt;

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    updown_sweep_ctrl #(.W(3), .PW(4)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop),
        .lo(lo), .hi(hi), .num_peaks(num_peaks), .q(q),
        .cnt_rst(cnt_rst), .updown(updown), .busy(busy),
        .done(done), .err(err), .peak_cnt(peak_cnt)
    );

    // The unchanged counter: counts every cycle unless held in reset.
    always_ff @(posedge clk) begin
        if (cnt_rst)     q <= 3'd0;
        else if (updown) q <= q + 3'd1;
        else             q <= q - 3'd1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) begin
            passes++;
        end else begin
            fails++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    int basic_q[17] = '{0,1,2,3,4,5,4,3,2,3,4,5,4,3,2,1,0};
    int small_q[7]  = '{0,1,2,3,2,1,0};
    int bound_q[15] = '{0,1,2,3,4,5,6,7,6,5,4,3,2,1,0};

    initial begin
        rst = 1'b1; start = 1'b1; stop = 1'b0;
        lo = 3'd2; hi = 3'd5; num_peaks = 4'd2;

        // Reset with start held high
        step(); step();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_peak", peak_cnt, 0);
        check("rst_cnt_rst", cnt_rst, 1);
        check("rst_q", q, 0);
        rst = 1'b0; start = 1'b0;
        step();
        check("post_rst_idle", busy, 0);

        // Basic sweep, with start-while-busy and a hi change mid-sweep
        start = 1'b1;
        step();
        start = 1'b0;
        check("basic_busy", busy, 1);
        for (int i = 0; i < 17; i++) begin
            check($sformatf("basic_q[%0d]", i), q, basic_q[i]);
            check($sformatf("basic_done[%0d]", i), done, 0);
            if (i == 3) begin start = 1'b1; hi = 3'd3; end
            if (i == 4) start = 1'b0;
            step();
        end
        check("basic_done", done, 1);
        check("basic_busy_low", busy, 0);
        check("basic_peak", peak_cnt, 2);
        check("basic_q_hold", q, 0);
        check("basic_no_err", err, 0);
        step();
        check("basic_done_once", done, 0);
        check("basic_peak_hold", peak_cnt, 2);

        // New sweep uses the updated hi=3
        num_peaks = 4'd1;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 7; i++) begin
            check($sformatf("hi3_q[%0d]", i), q, small_q[i]);
            step();
        end
        check("hi3_done", done, 1);
        check("hi3_peak", peak_cnt, 1);

        // Full range lo=0 hi=7: no wrap
        lo = 3'd0; hi = 3'd7; num_peaks = 4'd1;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 15; i++) begin
            check($sformatf("bound_q[%0d]", i), q, bound_q[i]);
            step();
        end
        check("bound_done", done, 1);
        check("bound_peak", peak_cnt, 1);
        check("bound_q_hold", q, 0);
        step();
        check("bound_done_once", done, 0);

        // Rejects
        lo = 3'd4; hi = 3'd4; num_peaks = 4'd2;
        start = 1'b1;
        step();
        start = 1'b0;
        check("rej_eq_err", err, 1);
        check("rej_eq_busy", busy, 0);
        check("rej_eq_done", done, 0);
        step();
        check("rej_eq_err_once", err, 0);
        lo = 3'd1; hi = 3'd5; num_peaks = 4'd0;
        start = 1'b1;
        step();
        start = 1'b0;
        check("rej_np0_err", err, 1);
        check("rej_np0_busy", busy, 0);
        check("rej_peak_kept", peak_cnt, 1);
        step();
        check("rej_np0_err_once", err, 0);

        // Abort at q=4 on the second rise of the basic sweep
        lo = 3'd2; hi = 3'd5; num_peaks = 4'd2;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 10; i++) step();
        check("abort_pre_q", q, 4);
        check("abort_pre_peak", peak_cnt, 1);
        stop = 1'b1;
        #1;
        check("abort_cnt_rst", cnt_rst, 1);
        step();
        stop = 1'b0;
        check("abort_q", q, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_peak", peak_cnt, 1);
        step();
        check("abort_no_done", done, 0);

        // Stop beats start in IDLE
        stop = 1'b1; start = 1'b1;
        step();
        stop = 1'b0; start = 1'b0;
        check("stopstart_busy", busy, 0);
        check("stopstart_err", err, 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/updown_sweep_ctrl.md
Name: updown_sweep_ctrl

Overview:
- Sequencer for the 3-bit synchronous up/down counter (ports clk, rst, updown, q, qbar).
- Drives the counter's rst and updown and watches its q, so the counter produces a ping-pong sweep: from 0 up to hi, then bouncing between lo and hi, then back down to 0.
- Sits between the control/config logic and the counter instance. The counter itself is unchanged and always counts when not in reset.

Parameters:
- W, 3, counter width; width of q, lo and hi.
- PW, 4, width of the peak-count config and status.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to begin a sweep; sampled only in IDLE.
- stop  in  1  abort; sampled in any state.
- lo  in  W  lower turnaround value; latched at accepted start.
- hi  in  W  upper turnaround value; latched at accepted start.
- num_peaks  in  PW  number of hi peaks before return; latched at accepted start.
- q  in  W  counter value feedback from counter q.
- cnt_rst  out  1  drives counter rst; combinational.
- updown  out  1  drives counter updown (1=up, 0=down); combinational.
- busy  out  1  high when state != IDLE; registered.
- done  out  1  one-cycle pulse at sweep completion; registered.
- err  out  1  one-cycle pulse on a rejected start; registered.
- peak_cnt  out  PW  peaks completed in current/last sweep; registered.

Behaviour:
- States: IDLE, RUN, RET. Registers: state, dir, lo_r, hi_r, np_r, peak_cnt, done, err.
- Reset (rst=1 at edge): state=IDLE, dir=1, peak_cnt=0, done=0, err=0, lo_r=hi_r=np_r=0. The cnt_rst=1 output then holds the counter at q=0. rst overrides every other input.
- cnt_rst = rst | (state==IDLE) | stop | (state==RET & q==0). This keeps q at 0 whenever the controller is idle and prevents a 0->7 wrap at the end of RET.
- updown:
  - IDLE: 1.
  - RUN: 0 if q>=hi_r; 1 if q<=lo_r; otherwise dir.
  - RET: 0.
  - dir <= updown every RUN cycle.
- IDLE:
  - start=1 with lo<hi and num_peaks!=0: latch lo, hi and num_peaks; peak_cnt<=0; dir<=1; go to RUN.
  - start=1 with lo>=hi or num_peaks==0: err pulses one cycle; stay IDLE; latched config unchanged.
- RUN:
  - q enters at 0. Each cycle with q==hi_r increments peak_cnt.
  - When the incremented value equals np_r, go to RET; the direction is already down.
  - Resulting q sequence: 0,1,...,hi,hi-1,...,lo,lo+1,...,hi,...
  - Turnaround has no dwell: each bound value appears for exactly one cycle.
- RET:
  - Count down to 0, ignoring lo_r.
  - In the cycle with q==0: done<=1 (visible next cycle, one cycle only), go to IDLE. The counter is held at 0 by cnt_rst.
  - busy drops in the same cycle that done is high.
- stop=1 (not in reset):
  - From any state: go to IDLE the next cycle; cnt_rst is asserted immediately.
  - No done pulse; peak_cnt holds its value.
  - In IDLE, stop has priority over start; the start is not accepted and no err pulses.
- start while busy is ignored. Changes to lo, hi or num_peaks after acceptance are ignored until the next accepted start.
- hi_r = 2^W-1 (7) is legal; the controller never commands past hi_r, so the counter never wraps.
- peak_cnt holds its final value after completion until the next accepted start or rst.
- done and err are never high in the same cycle.

Test Plan:
- Reset: assert rst 2 cycles with start=1 -> busy=0, done=0, err=0, peak_cnt=0, cnt_rst=1, q=0; start not accepted.
- Basic sweep with lo=2, hi=5, num_peaks=2, start pulse:
  - q = 0,1,2,3,4,5,4,3,2,3,4,5,4,3,2,1,0, then held at 0.
  - done pulses once, the cycle after q first returns to 0; peak_cnt=2; busy low from that cycle.
  - q never reads 7.
- Bounds lo=0, hi=7, num_peaks=1 -> q = 0..7 then 6..0, no wrap; done once; peak_cnt=1.
- Rejects:
  - lo=4, hi=4 start -> err one cycle, busy stays 0.
  - num_peaks=0 -> err one cycle.
  - start while busy -> ignored, sweep unaffected.
- Abort: stop asserted while q=4 in the second rise of the basic sweep -> cnt_rst=1 that cycle, q=0 next cycle, busy=0, no done, peak_cnt=1.
- Config change: change hi from 5 to 3 mid-sweep -> turnaround stays at 5; a new start after done uses hi=3.
